// File: rtl/ha_serial_add_ctrl.sv
// Bit-serial unsigned adder: one full-adder slice (two half adders) processes
// one operand bit per RUN cycle, LSB first, with a registered sum and carry out.
module ha_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       slice;

  // Returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
    logic [1:0] h0;
    logic [1:0] h1;
    h0 = half_add(x, y);
    h1 = half_add(h0[0], cin);
    return {h0[1] | h1[1], h1[0]};
  endfunction

  assign slice = full_add(op_a[0], op_b[0], carry);

  // Operand shifters carry only data, so they need no reset; bit 0 is always
  // the bit currently being added.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_a <= a;
      op_b <= b;
    end else if (state == RUN) begin
      op_a <= op_a >> 1;
      op_b <= op_b >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            carry     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
          end
        end
        RUN: begin
          sum[cnt] <= slice[0];
          carry    <= slice[1];
          if (cnt == LAST) begin
            cnt       <= '0;
            carry_out <= slice[1];
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ha_serial_add_ctrl.sv
// Directed and swept checks of the bit-serial adder at WIDTH=8.
module tb_ha_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ha_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
  );

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] es;
    logic         ec;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge while the DUT idles; returns at the falling edge
  // where done is seen (or after the cycle budget, with lat = -1).
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        output logic [W-1:0] rs, output logic rc,
                        output int lat, output int bcnt);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = -1;
    bcnt = 0;
    rs   = '0;
    rc   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        rs  = sum;
        rc  = carry_out;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    int           lat;
    int           bcnt;
    int           ndone;
    int           first_done;
    logic [W:0]   ref_sum;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           dk[3];

    vt[0] = '{8'h0F, 8'h01, 8'h10, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vt[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vt[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vt[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
    vt[5] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
    vt[6] = '{8'h12, 8'h34, 8'h46, 1'b0};
    vt[7] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    vt[8] = '{8'hC3, 8'h3D, 8'h00, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_start_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].va, vt[i].vb, rs, rc, lat, bcnt);
      check($sformatf("vec%0d_sum", i), 32'(rs), 32'(vt[i].es));
      check($sformatf("vec%0d_cout", i), 32'(rc), 32'(vt[i].ec));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd8);
      @(negedge clk);
      check($sformatf("vec%0d_done_one_cycle", i), 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_sum_hold", i), 32'(sum), 32'(vt[i].es));
      check($sformatf("vec%0d_cout_hold", i), 32'(carry_out), 32'(vt[i].ec));
    end

    // start re-asserted mid-RUN with new operands must be ignored
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0; first_done = -1; rs = '0; rc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 2) begin start = 1'b1; a = 8'hAA; b = 8'h55; end
      if (k == 3) start = 1'b0;
      if (done) begin
        ndone++;
        if (first_done < 0) begin first_done = k; rs = sum; rc = carry_out; end
      end
    end
    check("ignore_sum", 32'(rs), 32'h46);
    check("ignore_cout", 32'(rc), 32'd0);
    check("ignore_done_count", 32'(ndone), 32'd1);
    check("ignore_latency", 32'(first_done), 32'd8);

    // asynchronous reset in RUN cycle 4 aborts without a done pulse
    a = 8'h80; b = 8'h80; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(carry_out), 32'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b0;
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h80, 8'h80, rs, rc, lat, bcnt);
    check("post_rst_sum", 32'(rs), 32'h00);
    check("post_rst_cout", 32'(rc), 32'd1);
    check("post_rst_latency", 32'(lat), 32'd8);
    repeat (2) @(negedge clk);

    // start held high: back-to-back operations, period WIDTH+2
    a = 8'h01; b = 8'h01; start = 1'b1;
    @(posedge clk);
    ndone = 0;
    dk = '{-1, -1, -1};
    for (int k = 0; k < 40 && ndone < 3; k++) begin
      @(negedge clk);
      if (done) begin
        dk[ndone] = k;
        check($sformatf("b2b%0d_sum", ndone), 32'(sum), 32'h02);
        check($sformatf("b2b%0d_cout", ndone), 32'(carry_out), 32'd0);
        ndone++;
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(ndone), 32'd3);
    check("b2b_first", 32'(dk[0]), 32'd8);
    check("b2b_gap1", 32'(dk[1] - dk[0]), 32'd10);
    check("b2b_gap2", 32'(dk[2] - dk[1]), 32'd10);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      ref_sum = {1'b0, ra} + {1'b0, rb};
      run_op(ra, rb, rs, rc, lat, bcnt);
      check($sformatf("rand%0d_result %0h+%0h", i, ra, rb), 32'({rc, rs}), 32'(ref_sum));
      check($sformatf("rand%0d_busy_cycles", i), 32'(bcnt), 32'd8);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
